// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Execute-stage jump resolution. Holds the condition-code register (FLAG_W
//   flags), an interrupt shadow copy of it, and a two-state flush sequencer
//   that squashes younger stages for FLUSH_CYCLES unstalled cycles after a
//   taken jump.
//
//   Ports
//     clk, reset_n    rising-edge clock, asynchronous active-low reset
//     flag_wr_en      ALU flag update strobe, new values on flag_in
//     flag_save       interrupt entry: copy effective flags to the shadow
//     flag_restore    return from interrupt: load flags from the shadow
//     br_valid        jump instruction present in execute
//     br_uncond       unconditional jump (flags ignored)
//     br_polarity     0: jump if the tested flag is set, 1: if it is clear
//     br_sel          index of the tested flag
//     br_target       jump destination
//     stall           freezes jump evaluation and the flush counter
//     flags           current CCR
//     jump_taken      registered one-cycle pulse, jump_pc valid with it
//     jump_pc         registered jump target
//     flush           high while the sequencer is in FLUSH
// -----------------------------------------------------------------------------

// One CCR bit with its shadow copy. The effective value forwards a same-cycle
// restore or ALU write so that a jump in this cycle sees it.
module brf_flag_bit (
   input  logic clk,
   input  logic reset_n,
   input  logic wr_en_i,
   input  logic flag_i,
   input  logic save_i,
   input  logic restore_i,
   input  logic clr_i,
   output logic eff_o,
   output logic flag_o
);

   logic flag_q, flag_d;
   logic shadow_q, shadow_d;

   always_comb begin
      eff_o    = restore_i ? shadow_q : (wr_en_i ? flag_i : flag_q);
      flag_d   = eff_o & ~clr_i;
      // restore wins over a simultaneous save; shadow keeps its old value
      shadow_d = (save_i & ~restore_i) ? eff_o : shadow_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_q   <= 1'b0;
         shadow_q <= 1'b0;
      end else begin
         flag_q   <= flag_d;
         shadow_q <= shadow_d;
      end
   end

   assign flag_o = flag_q;

endmodule

module branch_resolve_unit #(
   parameter int FLAG_W        = 3,
   parameter int SEL_W         = 2,
   parameter int ADDR_W        = 16,
   parameter int FLUSH_CYCLES  = 2,
   parameter bit CLEAR_ON_TAKE = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flag_wr_en,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic              flag_save,
   input  logic              flag_restore,
   input  logic              br_valid,
   input  logic              br_uncond,
   input  logic              br_polarity,
   input  logic [SEL_W-1:0]  br_sel,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              stall,
   output logic [FLAG_W-1:0] flags,
   output logic              jump_taken,
   output logic [ADDR_W-1:0] jump_pc,
   output logic              flush
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   typedef struct packed {
      logic              valid;
      logic              uncond;
      logic              polarity;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] target;
   } br_req_t;

   br_req_t           req;
   logic [FLAG_W-1:0] eff;
   logic [FLAG_W-1:0] clr_mask;
   logic              sel_ok;
   logic              tested;
   logic              cond;
   logic              take;
   logic              clr_en;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              jt_q, jt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   assign req = '{valid:    br_valid,
                  uncond:   br_uncond,
                  polarity: br_polarity,
                  sel:      br_sel,
                  target:   br_target};

   // ---------------------------------------------------------------- CCR bits
   brf_flag_bit u_bit [FLAG_W-1:0] (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (flag_wr_en),
      .flag_i    (flag_in),
      .save_i    (flag_save),
      .restore_i (flag_restore),
      .clr_i     (clr_mask),
      .eff_o     (eff),
      .flag_o    (flags)
   );

   // ------------------------------------------------------------- condition
   // Out-of-range selects leave sel_ok low, so a conditional jump on a
   // non-existent flag is never taken regardless of polarity.
   always_comb begin
      sel_ok = 1'b0;
      tested = 1'b0;
      for (int i = 0; i < FLAG_W; i++) begin
         if (req.sel == SEL_W'(i)) begin
            sel_ok = 1'b1;
            tested = eff[i];
         end
      end
   end

   assign cond   = req.uncond | (sel_ok & (tested ^ req.polarity));
   assign take   = req.valid & cond & (state_q == S_IDLE) & ~stall;
   assign clr_en = CLEAR_ON_TAKE & take & ~req.uncond & ~req.polarity;

   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < FLAG_W; i++)
         clr_mask[i] = clr_en & (req.sel == SEL_W'(i));
   end

   // ------------------------------------------------------- flush sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      jt_d    = 1'b0;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            if (take) begin
               jt_d    = 1'b1;
               pc_d    = req.target;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // jumps arriving here belong to squashed instructions
            if (!stall) begin
               if (cnt_q == '0) state_d = S_IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         jt_q    <= 1'b0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         jt_q    <= jt_d;
         pc_q    <= pc_d;
      end
   end

   assign jump_taken = jt_q;
   assign jump_pc    = pc_q;
   assign flush      = (state_q == S_FLUSH);

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flag_wr_en, flag_save, flag_restore;
   logic [2:0]  flag_in;
   logic        br_valid, br_uncond, br_polarity, stall;
   logic [1:0]  br_sel;
   logic [15:0] br_target;
   logic [2:0]  flags;
   logic        jump_taken, flush;
   logic [15:0] jump_pc;

   branch_resolve_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flag_wr_en   (flag_wr_en),
      .flag_in      (flag_in),
      .flag_save    (flag_save),
      .flag_restore (flag_restore),
      .br_valid     (br_valid),
      .br_uncond    (br_uncond),
      .br_polarity  (br_polarity),
      .br_sel       (br_sel),
      .br_target    (br_target),
      .stall        (stall),
      .flags        (flags),
      .jump_taken   (jump_taken),
      .jump_pc      (jump_pc),
      .flush        (flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  flags;
      logic        jt;
      logic [15:0] pc;
      logic        flush;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference state
   logic [2:0]  m_flags, m_shadow;
   logic        m_flush, m_jt;
   logic [15:0] m_pc;
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flags = '0; m_shadow = '0; m_flush = 1'b0; m_jt = 1'b0; m_pc = '0; m_cnt = 0;
   endtask

   // Compute what the DUT should show after the coming edge and queue it.
   task automatic model_push();
      logic [2:0] eff;
      logic       sel_ok, tb, cond, take;
      exp_t       e;
      eff    = flag_restore ? m_shadow : (flag_wr_en ? flag_in : m_flags);
      sel_ok = (br_sel < 2'd3);
      tb     = sel_ok ? eff[br_sel] : 1'b0;
      cond   = br_uncond | (sel_ok & (tb ^ br_polarity));
      take   = br_valid & cond & ~m_flush & ~stall;
      if (flag_save && !flag_restore) m_shadow = eff;
      m_flags = eff;
      if (take && !br_uncond && !br_polarity) m_flags[br_sel] = 1'b0;
      if (!m_flush) begin
         m_jt = take;
         if (take) begin
            m_pc = br_target; m_cnt = FC - 1; m_flush = 1'b1;
         end
      end else begin
         m_jt = 1'b0;
         if (!stall) begin
            if (m_cnt == 0) m_flush = 1'b0;
            else            m_cnt--;
         end
      end
      e.flags = m_flags; e.jt = m_jt; e.pc = m_pc; e.flush = m_flush;
      sb.push_back(e);
   endtask

   task automatic step(input logic bv, input logic unc, input logic pol, input logic [1:0] sel,
                       input logic [15:0] tgt, input logic wr, input logic [2:0] fin,
                       input logic sv, input logic rs, input logic stl);
      exp_t e;
      br_valid = bv; br_uncond = unc; br_polarity = pol; br_sel = sel; br_target = tgt;
      flag_wr_en = wr; flag_in = fin; flag_save = sv; flag_restore = rs; stall = stl;
      model_push();
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
         e = sb.pop_front();
         chk("flags",      32'(flags),      32'(e.flags));
         chk("jump_taken", 32'(jump_taken), 32'(e.jt));
         chk("jump_pc",    32'(jump_pc),    32'(e.pc));
         chk("flush",      32'(flush),      32'(e.flush));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 16'h0, 0, 3'b000, 0, 0, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      br_valid = 0; br_uncond = 0; br_polarity = 0; br_sel = 0; br_target = 0;
      flag_wr_en = 0; flag_in = 0; flag_save = 0; flag_restore = 0; stall = 0;
      model_reset();
      #2;
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_jt",    32'(jump_taken), 32'd0);
      chk("rst_pc",    32'(jump_pc), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: jump-if-set on Z, clear-on-take, 2-cycle flush
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b001, 0, 0, 0);
      step(1, 0, 0, 2'd0, 16'h1234, 0, 3'b000, 0, 0, 0);
      chk("t1_pc",   32'(jump_pc), 32'h1234);
      chk("t1_flags", 32'(flags), 32'd0);
      idle(3);

      // 2: forwarded ALU write on C
      step(1, 0, 0, 2'd2, 16'h0BEE, 1, 3'b100, 0, 0, 0);
      chk("t2_jt", 32'(jump_taken), 32'd1);
      idle(3);

      // 3: jump-if-clear, then out-of-range selects with both polarities
      step(1, 0, 1, 2'd1, 16'h2222, 0, 3'b000, 0, 0, 0);
      chk("t3_jt", 32'(jump_taken), 32'd1);
      idle(3);
      step(1, 0, 0, 2'd3, 16'h3333, 0, 3'b000, 0, 0, 0);
      step(1, 0, 1, 2'd3, 16'h4444, 0, 3'b000, 0, 0, 0);
      chk("t3_sel3_jt", 32'(jump_taken), 32'd0);
      idle(1);

      // 4: jumps during FLUSH and under stall are ignored; stall stretches flush
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b011, 0, 0, 0);
      step(1, 0, 0, 2'd1, 16'h5555, 0, 3'b000, 0, 0, 1);   // stalled in IDLE
      chk("t4_stall_jt", 32'(jump_taken), 32'd0);
      step(1, 0, 0, 2'd0, 16'h6666, 0, 3'b000, 0, 0, 0);
      step(1, 0, 0, 2'd1, 16'h7777, 0, 3'b000, 0, 0, 0);   // squashed
      step(0, 0, 0, 2'd0, 16'h0, 0, 3'b000, 0, 0, 1);
      step(0, 0, 0, 2'd0, 16'h0, 0, 3'b000, 0, 0, 1);
      chk("t4_flush_held", 32'(flush), 32'd1);
      chk("t4_flag1_kept", 32'(flags), 32'b010);
      idle(3);

      // 5: save / restore, save+restore together leaves shadow alone
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b101, 0, 0, 0);
      step(0, 0, 0, 2'd0, 16'h0, 0, 3'b000, 1, 0, 0);
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b010, 0, 0, 0);
      step(0, 0, 0, 2'd0, 16'h0, 0, 3'b000, 0, 1, 0);
      chk("t5_restore", 32'(flags), 32'b101);
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b011, 0, 0, 0);
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b110, 1, 1, 0);
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b000, 0, 0, 0);
      step(0, 0, 0, 2'd0, 16'h0, 0, 3'b000, 0, 1, 0);
      chk("t5_shadow_kept", 32'(flags), 32'b101);

      // random mix
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
              2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 2) == 0),
              3'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0));
      idle(4);

      // 6: asynchronous reset in the middle of a flush
      step(0, 0, 0, 2'd0, 16'h0, 1, 3'b111, 0, 0, 0);
      step(1, 1, 0, 2'd0, 16'h9ABC, 0, 3'b000, 0, 0, 0);
      chk("t6_pre_flush", 32'(flush), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t6_flush", 32'(flush), 32'd0);
      chk("t6_jt",    32'(jump_taken), 32'd0);
      chk("t6_flags", 32'(flags), 32'd0);
      chk("t6_pc",    32'(jump_pc), 32'd0);
      model_reset();
      #2 reset_n = 1'b1;
      idle(2);
      step(1, 0, 1, 2'd2, 16'hCAFE, 0, 3'b000, 0, 0, 0);   // first jump after reset
      chk("t6_after_jt", 32'(jump_taken), 32'd1);
      idle(3);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
